// File: rtl/pid_tdm_pkg.sv
// Shared types for the time-multiplexed PID scheduler.
// PID_TDM_SCHED_DERIV_EN adds the derivative states MD/MN to the enum.
package pid_tdm_pkg;

  localparam int unsigned FP_W  = 32;
  localparam int unsigned SAT_W = 64;

  typedef logic signed [FP_W-1:0] fp_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MP   = 3'd1,
    S_MI   = 3'd2,
`ifdef PID_TDM_SCHED_DERIV_EN
    S_MD   = 3'd3,
    S_MN   = 3'd4,
`endif
    S_UPD  = 3'd5,
    S_OUT  = 3'd6
  } state_t;

  // Symmetric clamp of a W+1-bit sum; callers sign-extend into SAT_W bits.
  function automatic logic signed [SAT_W-1:0] sat_wp1(
    input logic signed [SAT_W-1:0] v,
    input logic signed [SAT_W-1:0] lim
  );
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

endpackage

// File: rtl/pid_fp_mul.sv
// Combinational signed fixed-point multiply: (a*b) >>> FW, truncated to W bits.
module pid_fp_mul #(
  parameter int unsigned W  = 32,
  parameter int unsigned FW = 16
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] p
);

  logic signed [2*W-1:0] full;

  assign full = a * b;
  assign p    = W'(full >>> FW);

endmodule

// File: rtl/pid_tdm_sched.sv
// NCH-channel PID controller sharing one multiplier, one channel at a time.
// Define PID_TDM_SCHED_DERIV_EN to include the filtered derivative path.
module pid_tdm_sched
  import pid_tdm_pkg::*;
#(
  parameter int unsigned W        = 32,
  parameter int unsigned FW       = 16,
  parameter int unsigned NCH      = 4,
  parameter int unsigned TICK_DIV = 100000,
  parameter logic signed [W-1:0] P_Q    = W'(65536),
  parameter logic signed [W-1:0] I_Q    = W'(256),
  parameter logic signed [W-1:0] D_Q    = '0,
  parameter logic signed [W-1:0] N_Q    = W'(32768),
  parameter logic signed [W-1:0] LIM_Q  = {1'b0, {(W-1){1'b1}}},
  parameter logic signed [W-1:0] DLIM_Q = {1'b0, {(W-1){1'b1}}}
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [NCH*W-1:0]        in_data,
  output logic signed [W-1:0]     out_data,
  output logic [$clog2(NCH)-1:0]  out_ch,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overrun
);

  localparam int unsigned CW = $clog2(NCH);
  localparam int unsigned TW = $clog2(TICK_DIV);

  typedef logic signed [W-1:0] word_t;

  state_t         state, nxt;
  logic [TW-1:0]  cnt;
  logic           tick;
  logic [CW-1:0]  ch;
  logic           last;

  word_t snap   [NCH];
  word_t xi_acc [NCH];
  word_t x, xp, xi, xnd;
  word_t mul_a, mul_b, prod;
  logic signed [W:0] isum;
  word_t xi_sat;

`ifdef PID_TDM_SCHED_DERIV_EN
  word_t dacc [NCH];
  word_t xd;
  logic signed [W:0] dsum;
  word_t d_sat;
`endif

  // Sample-period tick
  assign tick = en && (cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + TW'(1);
  end

  assign last      = (ch == CW'(NCH - 1));
  assign out_valid = (state == S_OUT);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (tick) nxt = S_MP;
      S_MP:   nxt = S_MI;
`ifdef PID_TDM_SCHED_DERIV_EN
      S_MI:   nxt = S_MD;
      S_MD:   nxt = S_MN;
      S_MN:   nxt = S_UPD;
`else
      S_MI:   nxt = S_UPD;
`endif
      S_UPD:  nxt = S_OUT;
      S_OUT:  if (out_ready) nxt = last ? S_IDLE : S_MP;
      default: nxt = S_IDLE;
    endcase
  end

  // Snapshot only on an accepted tick so overruns leave it untouched
  always_ff @(posedge clk) begin
    if (state == S_IDLE && tick) begin
      for (int unsigned i = 0; i < NCH; i++) snap[i] <= in_data[i*W +: W];
    end
  end

  assign x = snap[ch];

  always_comb begin
    mul_a = x;
    mul_b = P_Q;
    case (state)
      S_MI: mul_b = I_Q;
`ifdef PID_TDM_SCHED_DERIV_EN
      S_MD: mul_b = D_Q;
      S_MN: begin
        mul_a = xd - dacc[ch];
        mul_b = N_Q;
      end
`endif
      default: ;
    endcase
  end

  pid_fp_mul #(.W(W), .FW(FW)) u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (prod)
  );

  // One extra bit on the accumulator sums keeps overflow visible to the clamp
  assign isum   = {xi_acc[ch][W-1], xi_acc[ch]} + {xi[W-1], xi};
  assign xi_sat = W'(sat_wp1(SAT_W'(isum), SAT_W'(LIM_Q)));

`ifdef PID_TDM_SCHED_DERIV_EN
  assign dsum  = {dacc[ch][W-1], dacc[ch]} + {xnd[W-1], xnd};
  assign d_sat = W'(sat_wp1(SAT_W'(dsum), SAT_W'(DLIM_Q)));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCH; i++) dacc[i] <= '0;
      xd  <= '0;
      xnd <= '0;
    end else begin
      if (state == S_MD) xd <= prod;
      if (state == S_MN) xnd <= prod;
      if (state == S_UPD) dacc[ch] <= d_sat;
    end
  end
`else
  assign xnd = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCH; i++) xi_acc[i] <= '0;
      ch       <= '0;
      xp       <= '0;
      xi       <= '0;
      out_data <= '0;
      out_ch   <= '0;
      overrun  <= 1'b0;
    end else begin
      if (tick && state != S_IDLE) overrun <= 1'b1;
      case (state)
        S_IDLE: if (tick) ch <= '0;
        S_MP:   xp <= prod;
        S_MI:   xi <= prod;
        S_UPD: begin
          xi_acc[ch] <= xi_sat;
          out_data   <= xp + xi_acc[ch] + xnd;
          out_ch     <= ch;
        end
        S_OUT:  if (out_ready && !last) ch <= ch + CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pid_tdm_sched.sv
// Bench for pid_tdm_sched: three parameter sets share one stimulus, checked
// against a sample-level PID model; honours PID_TDM_SCHED_DERIV_EN.
module tb_pid_tdm_sched;

  localparam int NI   = 3;
  localparam int NCH  = 2;
  localparam int TDIV = 20;
`ifdef PID_TDM_SCHED_DERIV_EN
  localparam int LAT     = 6;
  localparam int RST_OFF = 10;
  localparam int DER0    = 32'h8000;
  localparam int DER1    = 32'h4000;
`else
  localparam int LAT     = 4;
  localparam int RST_OFF = 7;
  localparam int DER0    = 0;
  localparam int DER1    = 0;
`endif

  localparam int PQ [NI] = '{32'h80000, 0, 0};
  localparam int IQ [NI] = '{32'h4000, 32'h10000, 0};
  localparam int DQ [NI] = '{0, 0, 32'h10000};
  localparam int NQ [NI] = '{0, 0, 32'h8000};
  localparam int LQ [NI] = '{32'h7FFFFFFF, 32'h20000, 32'h7FFFFFFF};
  localparam int DL [NI] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF};

  logic clk, rst, en, out_ready;
  logic [NCH*32-1:0] in_data;
  logic signed [31:0] od  [NI];
  logic [0:0]         oc  [NI];
  logic               ov  [NI];
  logic               ovr [NI];

  pid_tdm_sched #(.W(32), .FW(16), .NCH(NCH), .TICK_DIV(TDIV),
    .P_Q(32'sh80000), .I_Q(32'sh4000), .D_Q(32'sh0), .N_Q(32'sh0),
    .LIM_Q(32'sh7FFFFFFF), .DLIM_Q(32'sh7FFFFFFF)) u_pi (
    .clk(clk), .rst(rst), .en(en), .in_data(in_data), .out_data(od[0]),
    .out_ch(oc[0]), .out_valid(ov[0]), .out_ready(out_ready), .overrun(ovr[0]));

  pid_tdm_sched #(.W(32), .FW(16), .NCH(NCH), .TICK_DIV(TDIV),
    .P_Q(32'sh0), .I_Q(32'sh10000), .D_Q(32'sh0), .N_Q(32'sh0),
    .LIM_Q(32'sh20000), .DLIM_Q(32'sh7FFFFFFF)) u_clamp (
    .clk(clk), .rst(rst), .en(en), .in_data(in_data), .out_data(od[1]),
    .out_ch(oc[1]), .out_valid(ov[1]), .out_ready(out_ready), .overrun(ovr[1]));

  pid_tdm_sched #(.W(32), .FW(16), .NCH(NCH), .TICK_DIV(TDIV),
    .P_Q(32'sh0), .I_Q(32'sh0), .D_Q(32'sh10000), .N_Q(32'sh8000),
    .LIM_Q(32'sh7FFFFFFF), .DLIM_Q(32'sh7FFFFFFF)) u_der (
    .clk(clk), .rst(rst), .en(en), .in_data(in_data), .out_data(od[2]),
    .out_ch(oc[2]), .out_valid(ov[2]), .out_ready(out_ready), .overrun(ovr[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit armed    = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // Sample-level model: tick timing, channel order, PID arithmetic
  int  cyc = 0, mcnt = 0, tick_cnt = 0, tick_at = 0;
  bit  busy [NI];
  bit  m_ovr [NI];
  int  cur [NI], nv [NI], exp_data [NI];
  int  snap_m [NI][NCH];
  int  acc_m  [NI][NCH];
  int  dacc_m [NI][NCH];

  function automatic int fx_mul(int a, int b);
    longint p;
    p = longint'(a) * longint'(b);
    return int'(p >>> 16);
  endfunction

  function automatic int clampl(longint v, int lim);
    if (v > longint'(lim)) return lim;
    if (v < -longint'(lim)) return -lim;
    return int'(v);
  endfunction

  task automatic serve(input int i, input int c);
    int x, xp, xi, xd, xnd;
    x   = snap_m[i][c];
    xp  = fx_mul(x, PQ[i]);
    xi  = fx_mul(x, IQ[i]);
`ifdef PID_TDM_SCHED_DERIV_EN
    xd  = fx_mul(x, DQ[i]);
    xnd = fx_mul(xd - dacc_m[i][c], NQ[i]);
`else
    xd  = 0;
    xnd = 0;
`endif
    exp_data[i]  = xp + acc_m[i][c] + xnd;
    acc_m[i][c]  = clampl(longint'(acc_m[i][c]) + longint'(xi), LQ[i]);
    dacc_m[i][c] = clampl(longint'(dacc_m[i][c]) + longint'(xnd), DL[i]);
  endtask

  initial begin
    forever begin
      bit tick_now, vexp;
      @(posedge clk);
      if (rst) begin
        mcnt = 0;
        for (int i = 0; i < NI; i++) begin
          busy[i] = 0; m_ovr[i] = 0;
          for (int c = 0; c < NCH; c++) begin acc_m[i][c] = 0; dacc_m[i][c] = 0; end
        end
      end else begin
        tick_now = en && (mcnt == TDIV - 1);
        for (int i = 0; i < NI; i++) begin
          vexp = busy[i] && (cyc >= nv[i]);
          if (tick_now) begin
            if (busy[i]) m_ovr[i] = 1;
            else begin
              busy[i] = 1; cur[i] = 0; nv[i] = cyc + LAT;
              for (int c = 0; c < NCH; c++) snap_m[i][c] = int'(in_data[c*32 +: 32]);
              serve(i, 0);
            end
          end
          if (vexp && out_ready) begin
            if (cur[i] == NCH - 1) busy[i] = 0;
            else begin cur[i]++; nv[i] = cyc + LAT; serve(i, cur[i]); end
          end
        end
        if (tick_now) begin tick_cnt++; tick_at = cyc; end
        if (en) mcnt = tick_now ? 0 : mcnt + 1;
      end
      cyc++;
    end
  end

  // Per-cycle comparison plus handshake logs for the literal checks
  int ch0_q [NI][$];
  int chseq [$];

  initial begin
    forever begin
      bit vexp;
      @(negedge clk);
      if (armed && !rst) begin
        for (int i = 0; i < NI; i++) begin
          vexp = busy[i] && (cyc >= nv[i]);
          chk($sformatf("valid[%0d]", i), 64'(ov[i]), 64'(vexp));
          chk($sformatf("overrun[%0d]", i), 64'(ovr[i]), 64'(m_ovr[i]));
          if (vexp) begin
            chk($sformatf("data[%0d]", i), 64'(od[i]), 64'(exp_data[i]));
            chk($sformatf("ch[%0d]", i), 64'(oc[i]), 64'(cur[i]));
          end
          if (ov[i] === 1'b1 && out_ready) begin
            if (oc[i] == 1'b0) ch0_q[i].push_back(int'(od[i]));
            if (i == 0) chseq.push_back(int'(oc[i]));
          end
        end
      end
    end
  end

  task automatic timeout(input string nm);
    n_checks++;
    $display("FAIL %s: got timeout expected event at t=%0t", nm, $time);
  endtask

  task automatic wait_tick();
    int start = tick_cnt;
    for (int k = 0; k < 100 && tick_cnt == start; k++) begin @(posedge clk); #1; end
    if (tick_cnt == start) timeout("tick");
  endtask

  task automatic wait_valid(input int c, output int at);
    at = -1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (ov[0] === 1'b1 && oc[0] == 1'(c)) begin at = cyc; break; end
    end
    if (at < 0) timeout($sformatf("valid_ch%0d", c));
  endtask

  task automatic chk_q(input string nm, input int i, input int k, input int exp);
    logic [63:0] act;
    act = 'x;
    if (ch0_q[i].size() > k) act = 64'(ch0_q[i][k]);
    chk(nm, act, 64'(exp));
  endtask

  initial begin
    int at, t0;
    logic signed [31:0] hold [NI];
    logic [63:0] a;
    rst = 1; en = 0; out_ready = 1;
    in_data = {32'h20000, 32'h10000};
    repeat (3) @(posedge clk);
    #1 rst = 0; en = 1; armed = 1;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_data[%0d]", i), 64'(od[i]), 64'd0);
      chk($sformatf("rst_valid[%0d]", i), 64'(ov[i]), 64'd0);
      chk($sformatf("rst_ovr[%0d]", i), 64'(ovr[i]), 64'd0);
    end

    // Four samples with ready high: latency and sequence literals
    wait_tick();
    t0 = tick_at;
    wait_valid(0, at);
    chk("lat_ch0", 64'(at), 64'(t0 + LAT));
    wait_valid(1, at);
    chk("lat_ch1", 64'(at), 64'(t0 + 2 * LAT));
    repeat (3) wait_tick();
    repeat (20) @(posedge clk);
    chk_q("pi_s0", 0, 0, 32'h80000);
    chk_q("pi_s1", 0, 1, 32'h84000);
    chk_q("clamp_s0", 1, 0, 0);
    chk_q("clamp_s1", 1, 1, 32'h10000);
    chk_q("clamp_s2", 1, 2, 32'h20000);
    chk_q("clamp_s3", 1, 3, 32'h20000);
    chk_q("der_s0", 2, 0, DER0);
    chk_q("der_s1", 2, 1, DER1);

    // Back-pressure across two dropped ticks
    chseq.delete();
    wait_tick();
    out_ready = 0;
    wait_valid(0, at);
    for (int i = 0; i < NI; i++) hold[i] = od[i];
    repeat (30) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("bp_stable[%0d]", i), 64'(od[i]), 64'(hold[i]));
      chk($sformatf("bp_ovr[%0d]", i), 64'(ovr[i]), 64'd1);
    end
    @(posedge clk); #1 out_ready = 1;
    repeat (30) @(posedge clk);
    a = 'x; if (chseq.size() > 0) a = 64'(chseq[0]);
    chk("bp_seq0", a, 64'd0);
    a = 'x; if (chseq.size() > 1) a = 64'(chseq[1]);
    chk("bp_seq1", a, 64'd1);

    // Reset in the middle of channel 1
    for (int k = 0; k < 100 && busy[0]; k++) begin @(posedge clk); #1; end
    wait_tick();
    repeat (RST_OFF - 1) begin @(posedge clk); #1; end
    rst = 1;
    @(posedge clk); #1 rst = 0;
    for (int i = 0; i < NI; i++) ch0_q[i].delete();
    chseq.delete();
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("mr_valid[%0d]", i), 64'(ov[i]), 64'd0);
      chk($sformatf("mr_ovr[%0d]", i), 64'(ovr[i]), 64'd0);
      chk($sformatf("mr_data[%0d]", i), 64'(od[i]), 64'd0);
    end
    wait_tick();
    repeat (20) @(posedge clk);
    a = 'x; if (chseq.size() > 0) a = 64'(chseq[0]);
    chk("mr_first_ch", a, 64'd0);
    chk_q("mr_pi", 0, 0, 32'h80000);
    chk_q("mr_clamp", 1, 0, 0);
    chk_q("mr_der", 2, 0, DER0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish by t=%0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/pid_tdm_sched.md
PID_TDM_SCHED -- requirements
Module: pid_tdm_sched

Interface
REQ-001 SHALL have parameter W, default 32, total fixed-point width.
REQ-002 SHALL have parameter FW, default 16, fraction bits.
REQ-003 SHALL have parameter NCH, default 4, number of PID channels (2..16).
REQ-004 SHALL have parameter TICK_DIV, default 100000, clocks per sample period.
REQ-005 SHALL have parameters P_Q, I_Q (I*TS), D_Q (D/TS), N_Q (N*TS), LIM_Q, DLIM_Q, all signed W-bit Q(W-FW).FW, shared by all channels.
REQ-006 SHALL have port clk, input, 1, clock.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port en, input, 1, enables the tick counter.
REQ-009 SHALL have port in_data, input, NCH*W, channel c at bits [c*W +: W], signed.
REQ-010 SHALL have port out_data, output, W, signed PID result.
REQ-011 SHALL have port out_ch, output, $clog2(NCH), channel of out_data.
REQ-012 SHALL have ports out_valid (output, 1) and out_ready (input, 1), valid/ready handshake.
REQ-013 SHALL have port overrun, output, 1, sticky sample-overrun flag.

Function
REQ-014 Tick: counter SHALL count 0..TICK_DIV-1 while en=1, hold while en=0, and assert an internal one-cycle tick on reaching TICK_DIV-1 before wrapping to 0.
REQ-015 On a tick in IDLE, all NCH inputs SHALL be latched into snapshot registers, channel index set to 0, and the FSM SHALL enter MP.
REQ-016 FSM states: IDLE, MP, MI, MD, MN, UPD, OUT. Each of MP..UPD lasts exactly one cycle, in that order.
REQ-017 One shared signed multiplier SHALL be used: product = (a*b) >>> FW, truncated to W bits. MP computes xp=x*P_Q, MI xi=x*I_Q, MD xd=x*D_Q, MN xnd=(xd-dacc[c])*N_Q.
REQ-018 In UPD: xi_acc[c] <= clamp(xi_acc[c]+xi, ±LIM_Q); dacc[c] <= clamp(dacc[c]+xnd, ±DLIM_Q); out_data <= xp + old xi_acc[c] + xnd. Sums and comparisons SHALL use W+1 bits so wrap-around cannot occur before clamping.
REQ-019 OUT SHALL hold out_valid=1 with stable out_data/out_ch until out_ready=1. On the handshake cycle it SHALL go to MP for c+1, or to IDLE if c=NCH-1.
REQ-020 Latency: for a tick in cycle T, ch0 out_valid SHALL first be high in T+6 (T+4 without derivative, see REQ-025). With out_ready tied high, each following channel SHALL follow 6 (4) cycles later.
REQ-021 A tick while not in IDLE SHALL be dropped, SHALL NOT alter the snapshot, and SHALL set overrun=1 until rst.
REQ-022 Channels SHALL be served strictly in ascending order. No channel is skipped, including under back-pressure.

Reset
REQ-023 rst SHALL force IDLE, tick counter=0, all xi_acc/dacc=0, out_data=0, out_ch=0, out_valid=0 and overrun=0, including mid-sequence and mid-handshake. In-flight results are discarded.

Configuration
REQ-024 Macro PID_TDM_SCHED_DERIV_EN defined: full P+I+D behaviour per REQ-016..018.
REQ-025 Macro PID_TDM_SCHED_DERIV_EN undefined: MD/MN states and dacc storage SHALL be removed, xnd=0, sequence MP->MI->UPD->OUT.

Structure
REQ-026 Package pid_tdm_pkg SHALL hold the FSM state enum, a W-bit fixed-point typedef, and the W+1-bit saturate function.
REQ-027 The shared multiplier SHALL be sub-module pid_fp_mul (combinational signed multiply, arithmetic shift by FW, truncate).

Verification (W=32, FW=16, NCH=2, TICK_DIV=20, derivative enabled unless stated)
REQ-028 Reset: hold rst 3 cycles -> out_data=0, out_valid=0, overrun=0; no out_valid until the first tick after release.
REQ-029 P/I step: P_Q=0x80000, I_Q=0x4000, D_Q=0, in ch0=0x10000, out_ready=1 -> ch0 outputs 0x80000 then 0x84000 on successive ticks; ch0 valid at T+6, ch1 valid at T+12.
REQ-030 Integrator clamp: P_Q=0, I_Q=0x10000, LIM_Q=0x20000, in=0x10000 -> ch0 outputs 0, 0x10000, 0x20000, 0x20000.
REQ-031 Derivative: P_Q=I_Q=0, D_Q=0x10000, N_Q=0x8000, DLIM_Q=0x7FFFFFFF, in=0x10000 -> ch0 outputs 0x8000 then 0x4000.
REQ-032 Back-pressure: out_ready=0 for 30 cycles after first out_valid -> out_data stable, overrun=1, then out_ch sequence 0,1 is preserved with nothing lost.
REQ-033 Mid-sequence reset: assert rst in state MN of ch1 -> next cycle out_valid=0, state IDLE, accumulators 0; the next tick restarts at ch0.
